// File: rtl/trivium_pkg.sv
// Shared defaults and state encoding for the Trivium key/IV loading path.
package trivium_pkg;

    localparam int IV_SZ_DEF  = 80;
    localparam int KEY_SZ_DEF = 80;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } ld_state_e;

endpackage

// File: rtl/key_iv_loader_byte_serializer.sv
// Parallel-in/serial-out stage: captures one word and emits it LSB first,
// one bit per cycle, with ce_o marking the valid bits.
module byte_serializer #(
    parameter int BYTE_W = 8
) (
    input  logic              clk_i,
    input  logic              n_rst_i,
    input  logic              clr,
    input  logic              load,
    input  logic [BYTE_W-1:0] dat,
    output logic              ce_o,
    output logic              bit_o,
    output logic              last_o
);

    localparam int CW = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;

    logic [BYTE_W-1:0] sbuf;
    logic [CW-1:0]     bit_cnt;
    logic              busy;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            sbuf    <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
        end else if (clr) begin
            sbuf    <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
        end else if (load) begin
            sbuf    <= dat;
            bit_cnt <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            sbuf <= sbuf >> 1;
            if (last_o) begin
                bit_cnt <= '0;
                busy    <= 1'b0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign ce_o   = busy;
    assign bit_o  = busy & sbuf[0];
    assign last_o = busy && (bit_cnt == CW'(BYTE_W - 1));

endmodule

// File: rtl/key_iv_loader.sv
// Byte-wide IV-then-key loader feeding the serial key/IV shift register.
// Optional odd-parity checking on input bytes with LOADER_PARITY_EN.
module key_iv_loader
    import trivium_pkg::*;
#(
    parameter int IV_SZ  = IV_SZ_DEF,
    parameter int KEY_SZ = KEY_SZ_DEF,
    parameter int BYTE_W = 8
) (
    input  logic              clk_i,
    input  logic              n_rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [BYTE_W-1:0] dat_i,
    input  logic              vld_i,
`ifdef LOADER_PARITY_EN
    input  logic              par_i,
    output logic              err_o,
`endif
    output logic              rdy_o,
    output logic              sr_dat_o,
    output logic              sr_ce_o,
    output logic              done_o,
    output logic              loaded_o
);

    localparam int NBYTES = (IV_SZ + KEY_SZ) / BYTE_W;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    generate
        if ((IV_SZ + KEY_SZ) % BYTE_W != 0) begin : g_bad_size
            $error("key_iv_loader: IV_SZ+KEY_SZ must be a multiple of BYTE_W");
        end
    endgenerate

    ld_state_e      state, nxt;
    logic [BCW-1:0] byte_cnt;
    logic           done_q;
    logic           hs, par_ok, ser_load, ser_ce, ser_bit, ser_last, last_byte;

    assign hs        = vld_i && rdy_o;
    assign last_byte = (byte_cnt == BCW'(NBYTES - 1));
`ifdef LOADER_PARITY_EN
    assign par_ok    = ^{dat_i, par_i};
`else
    assign par_ok    = 1'b1;
`endif
    // A bad-parity or aborted handshake must never reach the serializer.
    assign ser_load  = (state == ST_FILL) && hs && par_ok && !abort_i;

    byte_serializer #(.BYTE_W(BYTE_W)) u_ser (
        .clk_i  (clk_i),
        .n_rst_i(n_rst_i),
        .clr    (abort_i),
        .load   (ser_load),
        .dat    (dat_i),
        .ce_o   (ser_ce),
        .bit_o  (ser_bit),
        .last_o (ser_last)
    );

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            state  <= nxt;
            done_q <= (nxt == ST_DONE) && (state != ST_DONE);
            if (abort_i)
                byte_cnt <= '0;
            else if (start_i && (state == ST_IDLE || state == ST_DONE || state == ST_ERR))
                byte_cnt <= '0;
            else if (state == ST_SHIFT && ser_last && !last_byte)
                byte_cnt <= byte_cnt + 1'b1;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (start_i) nxt = ST_FILL;
            ST_FILL: begin
`ifdef LOADER_PARITY_EN
                if (hs) nxt = par_ok ? ST_SHIFT : ST_ERR;
`else
                if (hs) nxt = ST_SHIFT;
`endif
            end
            ST_SHIFT: if (ser_last) nxt = last_byte ? ST_DONE : ST_FILL;
            ST_DONE:  if (start_i) nxt = ST_FILL;
`ifdef LOADER_PARITY_EN
            ST_ERR:   if (start_i) nxt = ST_FILL;
`endif
            default:  nxt = ST_IDLE;
        endcase
        if (abort_i) nxt = ST_IDLE;
    end

    always_comb begin
        rdy_o    = (state == ST_FILL);
        sr_ce_o  = (state == ST_SHIFT) && ser_ce;
        sr_dat_o = sr_ce_o && ser_bit;
        done_o   = done_q;
        loaded_o = (state == ST_DONE);
`ifdef LOADER_PARITY_EN
        err_o    = (state == ST_ERR);
`endif
    end

endmodule

// File: tb/tb_key_iv_loader.sv
// Self-checking bench for key_iv_loader: control table, full/back-pressured
// loads against a 160-bit downstream image model, abort, reload and reset.
module tb_key_iv_loader;

    localparam int NB    = 20;
    localparam int IMG_W = 160;

    logic       clk_i = 1'b0, n_rst_i = 1'b0, start_i = 1'b0, abort_i = 1'b0, vld_i = 1'b0;
    logic [7:0] dat_i = '0;
    logic       rdy_o, sr_dat_o, sr_ce_o, done_o, loaded_o;
`ifdef LOADER_PARITY_EN
    logic       par_i = 1'b0;
    logic       err_o;
`endif

    int checks = 0, failures = 0;

    always #5 clk_i = ~clk_i;

    key_iv_loader dut (
        .clk_i   (clk_i),
        .n_rst_i (n_rst_i),
        .start_i (start_i),
        .abort_i (abort_i),
        .dat_i   (dat_i),
        .vld_i   (vld_i),
`ifdef LOADER_PARITY_EN
        .par_i   (par_i),
        .err_o   (err_o),
`endif
        .rdy_o   (rdy_o),
        .sr_dat_o(sr_dat_o),
        .sr_ce_o (sr_ce_o),
        .done_o  (done_o),
        .loaded_o(loaded_o)
    );

    // Downstream shift register: new bit enters at the top, so after 160
    // shifts stream bit k sits at position k.
    logic [IMG_W-1:0] img = '0;
    int ce_cnt = 0, done_cnt = 0, fill_ce_bad = 0, idle_dat_bad = 0;
    always @(negedge clk_i) if (n_rst_i) begin
        if (sr_ce_o) begin
            img    <= {sr_dat_o, img[IMG_W-1:1]};
            ce_cnt <= ce_cnt + 1;
        end else if (sr_dat_o) idle_dat_bad <= idle_dat_bad + 1;
        if (done_o) done_cnt <= done_cnt + 1;
        if (rdy_o && sr_ce_o) fill_ce_bad <= fill_ce_bad + 1;
    end

    logic [7:0] bq [NB];

    task automatic chk(input string name, input logic [IMG_W-1:0] act, input logic [IMG_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [IMG_W-1:0] exp_image();
        logic [IMG_W-1:0] e;
        e = '0;
        for (int i = 0; i < NB; i++) e[8*i +: 8] = bq[i];
        return e;
    endfunction

    task automatic drive_par();
`ifdef LOADER_PARITY_EN
        par_i = ~^dat_i;
`endif
    endtask

    // Start a load and feed bq[]; gaps of 0..gap_max idle cycles between bytes.
    // abort_at >= 0 asserts abort+start together when that byte is offered.
    task automatic run_load(input int gap_max, input int abort_at, input logic check_latency);
        int   idx, gap, n, done_at, ce0, dn0, bad0;
        logic hs, aborted;
        idx = 0; n = 0; done_at = -1; aborted = 1'b0;
        ce0 = ce_cnt; dn0 = done_cnt; bad0 = fill_ce_bad;
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        chk("start_rdy", IMG_W'(rdy_o), 1);
        chk("start_loaded", IMG_W'(loaded_o), 0);
        gap = $urandom_range(0, gap_max);
        while (n < 3000) begin
            vld_i = (idx < NB) && (gap == 0);
            dat_i = vld_i ? bq[idx] : 8'($urandom);
            drive_par();
            if (idx == abort_at && vld_i) begin abort_i = 1'b1; start_i = 1'b1; end
            @(negedge clk_i);
            hs = vld_i && rdy_o;
            if (done_o) done_at = n;
            if (hs) begin idx++; gap = $urandom_range(0, gap_max); end
            else if (gap > 0) gap--;
            @(posedge clk_i); #1;
            if (abort_i) begin aborted = 1'b1; abort_i = 1'b0; start_i = 1'b0; break; end
            n++;
            if (done_at >= 0) break;
        end
        vld_i = 1'b0;
        if (aborted) begin
            chk("abort_rdy", IMG_W'(rdy_o), 0);
            chk("abort_loaded", IMG_W'(loaded_o), 0);
            chk("abort_ce", IMG_W'(sr_ce_o), 0);
            repeat (30) @(posedge clk_i);
            #1 chk("abort_no_done", IMG_W'(done_cnt - dn0), 0);
            chk("abort_stays_idle", IMG_W'(rdy_o | loaded_o), 0);
        end else begin
            chk("done_seen", IMG_W'(done_at >= 0), 1);
            if (check_latency) chk("done_cycle", IMG_W'(done_at), 180);
            chk("ce_pulses", IMG_W'(ce_cnt - ce0), 160);
            chk("image", img, exp_image());
            chk("loaded", IMG_W'(loaded_o), 1);
            @(posedge clk_i); #1;
            chk("done_single", IMG_W'({done_o, loaded_o}), 1);
            chk("done_count", IMG_W'(done_cnt - dn0), 1);
            chk("no_ce_in_fill", IMG_W'(fill_ce_bad - bad0), 0);
        end
    endtask

    typedef struct {
        logic       start, abort, vld;
        logic [7:0] dat;
        logic [4:0] exp;   // {rdy, sr_ce, sr_dat, done, loaded} after the edge
    } vec_t;

    vec_t tbl [14];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{0, 0, 0, 8'h00, 5'b00000};
        tbl[1]  = '{0, 0, 1, 8'hFF, 5'b00000};
        tbl[2]  = '{1, 0, 0, 8'h00, 5'b10000};
        tbl[3]  = '{1, 0, 0, 8'h00, 5'b10000};
        tbl[4]  = '{0, 0, 1, 8'h01, 5'b01100};
        tbl[5]  = '{1, 0, 0, 8'h00, 5'b01000};
        tbl[6]  = '{0, 1, 0, 8'h00, 5'b00000};
        tbl[7]  = '{1, 1, 0, 8'h00, 5'b00000};
        tbl[8]  = '{1, 0, 0, 8'h00, 5'b10000};
        tbl[9]  = '{0, 1, 1, 8'hFF, 5'b00000};
        tbl[10] = '{1, 0, 0, 8'h00, 5'b10000};
        tbl[11] = '{0, 0, 1, 8'h03, 5'b01100};
        tbl[12] = '{0, 0, 1, 8'hAA, 5'b01100};
        tbl[13] = '{0, 1, 0, 8'h00, 5'b00000};

        #12;
        chk("reset_state", IMG_W'({rdy_o, sr_ce_o, sr_dat_o, done_o, loaded_o}), 0);
        @(posedge clk_i); #1 n_rst_i = 1'b1;

        for (int i = 0; i < 14; i++) begin
            start_i = tbl[i].start; abort_i = tbl[i].abort;
            vld_i = tbl[i].vld; dat_i = tbl[i].dat;
            drive_par();
            @(posedge clk_i); #1;
            chk($sformatf("vec%0d", i), IMG_W'({rdy_o, sr_ce_o, sr_dat_o, done_o, loaded_o}), IMG_W'(tbl[i].exp));
        end
        start_i = 1'b0; abort_i = 1'b0; vld_i = 1'b0;

        for (int i = 0; i < NB; i++) bq[i] = 8'(i);
        run_load(0, -1, 1'b1);

        for (int i = 0; i < NB; i++) bq[i] = 8'($urandom);
        run_load(3, -1, 1'b0);

        for (int i = 0; i < NB; i++) bq[i] = 8'hFF;
        run_load(0, -1, 1'b1);

        for (int i = 0; i < NB; i++) bq[i] = 8'($urandom);
        run_load(0, 7, 1'b0);
        run_load(0, -1, 1'b1);

        // asynchronous reset while a byte is being shifted out
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0; vld_i = 1'b1; dat_i = 8'h5A; drive_par();
        @(posedge clk_i); #1 vld_i = 1'b0;
        chk("pre_reset_shift", IMG_W'(sr_ce_o), 1);
        #2 n_rst_i = 1'b0;
        #1 chk("reset_mid_shift", IMG_W'({rdy_o, sr_ce_o, sr_dat_o, done_o, loaded_o}), 0);
        @(posedge clk_i); #1 n_rst_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        chk("post_reset_rdy", IMG_W'(rdy_o), 1);
        abort_i = 1'b1;
        @(posedge clk_i); #1 abort_i = 1'b0;

`ifdef LOADER_PARITY_EN
        // 0xA5 has four ones; par_i=0 gives an even total and must be rejected
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0; vld_i = 1'b1; dat_i = 8'hA5; par_i = 1'b0;
        @(posedge clk_i); #1 vld_i = 1'b0;
        chk("par_err", IMG_W'({err_o, rdy_o, sr_ce_o}), 3'b100);
        @(posedge clk_i); #1;
        chk("par_err_hold", IMG_W'({err_o, sr_ce_o}), 2'b10);
        start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        chk("par_clear", IMG_W'({err_o, rdy_o}), 2'b01);
        abort_i = 1'b1;
        @(posedge clk_i); #1 abort_i = 1'b0;
        for (int i = 0; i < NB; i++) bq[i] = 8'($urandom);
        run_load(1, -1, 1'b0);
`endif

        chk("no_dat_without_ce", IMG_W'(idle_dat_bad), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
